// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for branch-resolution bookkeeping and commit-time redirect sequencing.
package branch_redirect_ctrl_pkg;

  localparam int DEF_ROB_DEPTH = 16;
  localparam int DEF_ROB_IDX_W = $clog2(DEF_ROB_DEPTH);
  localparam int DEF_CNT_W     = 32;

  typedef logic [DEF_ROB_IDX_W-1:0] rob_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    DRAIN    = 2'd3
  } redirect_state_t;

  typedef struct packed {
    logic        v;
    logic        f;
    logic [31:0] pc;
  } br_table_entry_t;

endpackage

// File: rtl/branch_redirect_ctrl_table.sv
// Resolved-branch table: one entry per ROB slot, single write port, single read port
// with same-cycle write bypass, per-entry consume and clear-all.
module branch_redirect_ctrl_table
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_ROB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_f,
  input  logic [31:0]      wr_pc,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             clr_all,
  output br_table_entry_t  rd_entry
);

  logic [DEPTH-1:0] v_reg;
  logic [DEPTH-1:0] f_reg;
  logic [31:0]      pc_mem [DEPTH];
  logic             bypass;

  assign bypass = wr_en && (wr_idx == rd_idx);

  always_comb begin
    rd_entry = '0;
    if (bypass) begin
      rd_entry.v  = 1'b1;
      rd_entry.f  = wr_f;
      rd_entry.pc = wr_pc;
    end else begin
      rd_entry.v  = v_reg[rd_idx];
      rd_entry.f  = f_reg[rd_idx];
      rd_entry.pc = pc_mem[rd_idx];
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // A consume in the same cycle as a write to the slot wins: the bypassed write is never stored.
    always_ff @(posedge clk) begin
      if (rst || clr_all) begin
        v_reg[gi] <= 1'b0;
        f_reg[gi] <= 1'b0;
      end else if (rd_en && (rd_idx == IDX_W'(gi))) begin
        v_reg[gi] <= 1'b0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        v_reg[gi] <= 1'b1;
        f_reg[gi] <= wr_f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_idx] <= wr_pc;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Holds resolved branches until commit, then sequences flush, fetch redirect and imem drain.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int ROB_DEPTH = DEF_ROB_DEPTH,
  parameter int ROB_IDX_W = $clog2(ROB_DEPTH),
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic [ROB_IDX_W-1:0] br_rob_idx,
  input  logic                 br_flush,
  input  logic [31:0]          br_pc,
  input  logic                 commit_valid,
  input  logic [ROB_IDX_W-1:0] commit_rob_idx,
  input  logic                 fetch_ready,
  input  logic                 imem_pending,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 stall_commit,
  output logic [CNT_W-1:0]     mispredict_cnt
);

  redirect_state_t state_reg, state_next;
  br_table_entry_t lookup;
  logic            in_idle;
  logic            flush_reg, redirect_valid_reg, stall_commit_reg;
  logic [31:0]     redirect_pc_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign in_idle = (state_reg == IDLE);

  // Commits seen while stalled are ignored because lookup/consume only run in IDLE.
  branch_redirect_ctrl_table #(
    .DEPTH (ROB_DEPTH),
    .IDX_W (ROB_IDX_W)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (br_valid && in_idle),
    .wr_idx   (br_rob_idx),
    .wr_f     (br_flush),
    .wr_pc    (br_pc),
    .rd_en    (commit_valid && in_idle),
    .rd_idx   (commit_rob_idx),
    .clr_all  (state_reg == FLUSH),
    .rd_entry (lookup)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (commit_valid && lookup.v && lookup.f) state_next = FLUSH;
      FLUSH:    state_next = REDIRECT;
      REDIRECT: if (fetch_ready) state_next = DRAIN;
      DRAIN:    if (!imem_pending) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      stall_commit_reg   <= 1'b0;
      cnt_reg            <= '0;
    end else begin
      state_reg          <= state_next;
      flush_reg          <= (state_next == FLUSH);
      redirect_valid_reg <= (state_next == REDIRECT);
      stall_commit_reg   <= (state_next != IDLE);
      if (in_idle && (state_next == FLUSH)) begin
        redirect_pc_reg <= lookup.pc;
      end
      if ((state_reg == REDIRECT) && fetch_ready) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign flush          = flush_reg;
  assign redirect_valid = redirect_valid_reg;
  assign redirect_pc    = redirect_pc_reg;
  assign stall_commit   = stall_commit_reg;
  assign mispredict_cnt = cnt_reg;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with a scoreboard of expected redirect targets and counts.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [3:0]  br_rob_idx;
  logic        br_flush;
  logic [31:0] br_pc;
  logic        commit_valid;
  logic [3:0]  commit_rob_idx;
  logic        fetch_ready;
  logic        imem_pending;

  logic        flush, redirect_valid, stall_commit;
  logic [31:0] redirect_pc, mispredict_cnt;
  logic        flush_w, redirect_valid_w, stall_commit_w;
  logic [31:0] redirect_pc_w;
  logic [3:0]  mispredict_cnt_w;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_cnt_q[$];
  int          model_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_rob_idx(br_rob_idx),
    .br_flush(br_flush), .br_pc(br_pc), .commit_valid(commit_valid),
    .commit_rob_idx(commit_rob_idx), .fetch_ready(fetch_ready),
    .imem_pending(imem_pending), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_commit(stall_commit),
    .mispredict_cnt(mispredict_cnt)
  );

  // Narrow-counter copy on the same stimulus, used to reach the counter wrap quickly.
  branch_redirect_ctrl #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_rob_idx(br_rob_idx),
    .br_flush(br_flush), .br_pc(br_pc), .commit_valid(commit_valid),
    .commit_rob_idx(commit_rob_idx), .fetch_ready(fetch_ready),
    .imem_pending(imem_pending), .flush(flush_w), .redirect_valid(redirect_valid_w),
    .redirect_pc(redirect_pc_w), .stall_commit(stall_commit_w),
    .mispredict_cnt(mispredict_cnt_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [3:0] idx, input logic f, input logic [31:0] pc);
    br_valid = 1'b1; br_rob_idx = idx; br_flush = f; br_pc = pc;
  endtask

  task automatic drive_commit(input logic [3:0] idx, input logic exp_flush, input logic [31:0] pc);
    commit_valid = 1'b1; commit_rob_idx = idx;
    if (exp_flush) exp_pc_q.push_back(pc);
  endtask

  task automatic clear_in();
    br_valid = 1'b0; br_flush = 1'b0; br_pc = '0; br_rob_idx = '0;
    commit_valid = 1'b0; commit_rob_idx = '0; fetch_ready = 1'b0;
  endtask

  task automatic wait_redirect(input string tag);
    int n = 0;
    while (redirect_valid !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
    if (exp_pc_q.size() > 0) chk({tag, "_pc"}, redirect_pc, exp_pc_q.pop_front());
    else chk({tag, "_pc_unexpected"}, redirect_pc, 32'hDEAD_BEEF);
  endtask

  task automatic accept(input string tag);
    fetch_ready = 1'b1;
    model_cnt++;
    exp_cnt_q.push_back(32'(model_cnt));
    tick();
    fetch_ready = 1'b0;
    chk({tag, "_rv_drop"}, {31'd0, redirect_valid}, 32'd0);
    chk({tag, "_cnt"}, mispredict_cnt, exp_cnt_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int stale [4] = '{2, 9, 7, 4};
    rst = 1'b1; imem_pending = 1'b0; model_cnt = 0;
    clear_in();
    tick(); tick();
    rst = 1'b0;
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    chk("rst_pc", redirect_pc, 32'd0);
    chk("rst_stall", {31'd0, stall_commit}, 32'd0);
    chk("rst_cnt", mispredict_cnt, 32'd0);

    // 1: basic flush / redirect / accept
    drive_br(4'd3, 1'b1, 32'h1F00_0040); tick(); clear_in();
    drive_commit(4'd3, 1'b1, 32'h1F00_0040); tick(); clear_in();
    chk("t1_flush", {31'd0, flush}, 32'd1);
    chk("t1_stall", {31'd0, stall_commit}, 32'd1);
    chk("t1_rv_early", {31'd0, redirect_valid}, 32'd0);
    tick();
    chk("t1_flush_pulse", {31'd0, flush}, 32'd0);
    wait_redirect("t1");
    accept("t1");
    chk("t1_drain_stall", {31'd0, stall_commit}, 32'd1);
    tick();
    chk("t1_idle_stall", {31'd0, stall_commit}, 32'd0);

    // 2: non-taken branch commits silently
    drive_br(4'd5, 1'b0, 32'h0000_0ABC); tick(); clear_in();
    drive_commit(4'd5, 1'b0, 32'h0); tick(); clear_in();
    chk("t2_flush", {31'd0, flush}, 32'd0);
    chk("t2_stall", {31'd0, stall_commit}, 32'd0);
    tick();
    chk("t2_flush_late", {31'd0, flush}, 32'd0);
    chk("t2_rv", {31'd0, redirect_valid}, 32'd0);

    // 3: stale entries, then same-cycle write+commit bypass
    drive_br(4'd2, 1'b1, 32'h0000_0200); tick();
    drive_br(4'd9, 1'b1, 32'h0000_0900); tick();
    drive_br(4'd7, 1'b1, 32'h0000_0100);
    drive_commit(4'd7, 1'b1, 32'h0000_0100); tick(); clear_in();
    chk("t3_flush", {31'd0, flush}, 32'd1);
    drive_br(4'd4, 1'b1, 32'h0000_0400); tick(); clear_in();
    wait_redirect("t3");

    // 4: fetch back-pressure keeps the offer stable
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t4_rv_%0d", k), {31'd0, redirect_valid}, 32'd1);
      chk($sformatf("t4_pc_%0d", k), redirect_pc, 32'h0000_0100);
      chk($sformatf("t4_stall_%0d", k), {31'd0, stall_commit}, 32'd1);
    end

    // 5: drain waits on imem_pending; stale entries are gone afterwards
    imem_pending = 1'b1;
    accept("t5");
    chk("t5_drain0", {31'd0, stall_commit}, 32'd1);
    tick();
    chk("t5_drain1", {31'd0, stall_commit}, 32'd1);
    tick();
    chk("t5_drain2", {31'd0, stall_commit}, 32'd1);
    imem_pending = 1'b0;
    tick();
    chk("t5_idle", {31'd0, stall_commit}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      drive_commit(4'(stale[s]), 1'b0, 32'h0); tick(); clear_in();
      chk($sformatf("t5_stale_%0d", stale[s]), {31'd0, flush}, 32'd0);
    end
    tick();
    chk("t5_stale_stall", {31'd0, stall_commit}, 32'd0);

    // 6a: reset empties the table
    drive_br(4'd6, 1'b1, 32'h0000_0600); tick(); clear_in();
    rst = 1'b1; tick(); rst = 1'b0; model_cnt = 0;
    chk("t6_rst_cnt", mispredict_cnt, 32'd0);
    drive_commit(4'd6, 1'b0, 32'h0); tick(); clear_in();
    chk("t6_rst_table", {31'd0, flush}, 32'd0);

    // 6b: reset while in REDIRECT
    drive_br(4'd1, 1'b1, 32'h0000_0040);
    drive_commit(4'd1, 1'b1, 32'h0000_0040); tick(); clear_in();
    tick();
    wait_redirect("t6");
    rst = 1'b1; tick(); rst = 1'b0; model_cnt = 0;
    chk("t6_flush", {31'd0, flush}, 32'd0);
    chk("t6_rv", {31'd0, redirect_valid}, 32'd0);
    chk("t6_pc", redirect_pc, 32'd0);
    chk("t6_stall", {31'd0, stall_commit}, 32'd0);
    chk("t6_cnt", mispredict_cnt, 32'd0);

    // 6c: counter wrap on the narrow instance
    for (int i = 0; i < 17; i++) begin
      drive_br(4'(i), 1'b1, 32'h0000_1000 + 32'(i * 4));
      drive_commit(4'(i), 1'b1, 32'h0000_1000 + 32'(i * 4)); tick(); clear_in();
      chk($sformatf("wrap_flush_%0d", i), {31'd0, flush}, 32'd1);
      tick();
      wait_redirect($sformatf("wrap_%0d", i));
      accept($sformatf("wrap_%0d", i));
      chk($sformatf("wrap_cnt4_%0d", i), {28'd0, mispredict_cnt_w}, 32'(model_cnt % 16));
      tick();
      chk($sformatf("wrap_idle_%0d", i), {31'd0, stall_commit}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
